// File: rtl/regfile_pkg.sv
// Shared register-file constants: data width, register count, index type and the zero register.
// Latency: n/a (package only). Backpressure: n/a.
package regfile_pkg;

    localparam int WORD  = 64;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a register, forces XZR to 0, optional write-through (REGFILE_BYPASS_EN).
// Latency: zero cycles. Backpressure: none, always valid.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WORD  = regfile_pkg::WORD,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic [NREGS-1:0][WORD-1:0] regs_i,
    input  logic [4:0]                 rd_idx_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [4:0]                 wr_idx_i,
    input  logic [WORD-1:0]            wr_data_i,
`endif
    output logic [WORD-1:0]            rd_data_o
);

    always_comb begin
        rd_data_o = '0;
        if (rd_idx_i != ZERO_REG && int'(rd_idx_i) < NREGS) begin
            rd_data_o = regs_i[rd_idx_i];
        end
`ifdef REGFILE_BYPASS_EN
        // Forwarding is held off during reset so outputs stay at 0.
        if (rst_n && wr_en_i && (wr_idx_i == rd_idx_i) && (rd_idx_i != ZERO_REG)) begin
            rd_data_o = wr_data_i;
        end
`endif
    end

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file with hard-wired zero register 31; REGFILE_BYPASS_EN adds write-through.
// Latency: reads combinational, writes on rising clk. Backpressure: none.
module regfile
    import regfile_pkg::*;
#(
    parameter int WORD  = regfile_pkg::WORD,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      read_register1,
    input  logic [4:0]      read_register2,
    input  logic [4:0]      write_register,
    input  logic            RegWrite,
    input  logic [WORD-1:0] write_data,
    output logic [WORD-1:0] read_data1,
    output logic [WORD-1:0] read_data2
);

    logic [NREGS-1:0][WORD-1:0] regs_q;
    logic [NREGS-1:0][WORD-1:0] regs_d;

    // Register 31 is never loaded, so it stays at its reset value of 0.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite && write_register != ZERO_REG && int'(write_register) < NREGS) begin
            regs_d[write_register] = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port #(
        .WORD  (WORD),
        .NREGS (NREGS)
    ) u_rd_port1 (
        .regs_i    (regs_q),
        .rd_idx_i  (read_register1),
`ifdef REGFILE_BYPASS_EN
        .rst_n     (rst_n),
        .wr_en_i   (RegWrite),
        .wr_idx_i  (write_register),
        .wr_data_i (write_data),
`endif
        .rd_data_o (read_data1)
    );

    regfile_read_port #(
        .WORD  (WORD),
        .NREGS (NREGS)
    ) u_rd_port2 (
        .regs_i    (regs_q),
        .rd_idx_i  (read_register2),
`ifdef REGFILE_BYPASS_EN
        .rst_n     (rst_n),
        .wr_en_i   (RegWrite),
        .wr_idx_i  (write_register),
        .wr_data_i (write_data),
`endif
        .rd_data_o (read_data2)
    );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile: reset, writes, XZR, same-cycle read/write, async reset.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [4:0]  write_register;
    logic        RegWrite;
    logic [63:0] write_data;
    logic [63:0] read_data1;
    logic [63:0] read_data2;

    int n_tests = 0;
    int n_fail  = 0;

    regfile dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_register1 (read_register1),
        .read_register2 (read_register2),
        .write_register (write_register),
        .RegWrite       (RegWrite),
        .write_data     (write_data),
        .read_data1     (read_data1),
        .read_data2     (read_data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        read_register1 = a;
        read_register2 = b;
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [63:0] dat);
        RegWrite       = 1'b1;
        write_register = idx;
        write_data     = dat;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    initial begin
        logic [4:0] pair_a [3];
        logic [4:0] pair_b [3];
        logic [63:0] same_cycle_exp;
        pair_a = '{5'd1, 5'd29, 5'd15};
        pair_b = '{5'd3, 5'd31, 5'd9};

        rst_n          = 1'b1;
        RegWrite       = 1'b0;
        write_register = '0;
        write_data     = '0;
        read_register1 = 5'd1;
        read_register2 = 5'd3;
        @(posedge clk);
        @(negedge clk);

        // Reset pulse mid-cycle; reads must clear without any clock edge.
        rst_n = 1'b0;
        rd(5'd1, 5'd3);
        check("rst_rd1_x1", read_data1, 64'd0);
        check("rst_rd2_x3", read_data2, 64'd0);
        rd(5'd29, 5'd31);
        check("rst_rd1_x29", read_data1, 64'd0);
        check("rst_rd2_x31", read_data2, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write to X0.
        wr(5'd0, 64'd4783);
        rd(5'd0, 5'd0);
        check("x0_rd1", read_data1, 64'd4783);
        check("x0_rd2", read_data2, 64'd4783);
        for (int i = 0; i < 3; i++) begin
            rd(pair_a[i], pair_b[i]);
            check($sformatf("zero_rd1_x%0d", pair_a[i]), read_data1, 64'd0);
            check($sformatf("zero_rd2_x%0d", pair_b[i]), read_data2, 64'd0);
        end

        // Retarget to X13, then idle edges with RegWrite low.
        wr(5'd13, 64'd4783);
        rd(5'd13, 5'd0);
        check("x13_rd1", read_data1, 64'd4783);
        write_data = 64'd3987;
        repeat (3) @(posedge clk);
        #1;
        check("x13_hold", read_data1, 64'd4783);
        check("x0_hold", read_data2, 64'd4783);

        // XZR: write during same cycle and after the edge both read 0.
        RegWrite       = 1'b1;
        write_register = 5'd31;
        write_data     = 64'hFFFF_FFFF_FFFF_FFFF;
        rd(5'd31, 5'd31);
        check("xzr_same_rd1", read_data1, 64'd0);
        check("xzr_same_rd2", read_data2, 64'd0);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        rd(5'd31, 5'd31);
        check("xzr_after_rd1", read_data1, 64'd0);
        check("xzr_after_rd2", read_data2, 64'd0);

        // Same-cycle write of X7 with both ports reading it.
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 64'd42;
`else
        same_cycle_exp = 64'd0;
`endif
        RegWrite       = 1'b1;
        write_register = 5'd7;
        write_data     = 64'd42;
        rd(5'd7, 5'd7);
        check("x7_before_rd1", read_data1, same_cycle_exp);
        check("x7_before_rd2", read_data2, same_cycle_exp);
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        check("x7_after_rd1", read_data1, 64'd42);
        check("x7_after_rd2", read_data2, 64'd42);

        // Async reset mid-operation with a write attempted during reset.
        rd(5'd0, 5'd13);
        check("pre_rst_x0", read_data1, 64'd4783);
        check("pre_rst_x13", read_data2, 64'd4783);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_x0", read_data1, 64'd0);
        check("mid_rst_x13", read_data2, 64'd0);
        RegWrite       = 1'b1;
        write_register = 5'd5;
        write_data     = 64'd99;
        rd(5'd5, 5'd7);
        check("rst_wr_rd1_x5", read_data1, 64'd0);
        check("rst_rd2_x7", read_data2, 64'd0);
        @(posedge clk);
        #1;
        check("rst_edge_x5", read_data1, 64'd0);
        RegWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(5'd5, 5'd13);
        check("post_rst_x5", read_data1, 64'd0);
        check("post_rst_x13", read_data2, 64'd0);
        rd(5'd0, 5'd7);
        check("post_rst_x0", read_data1, 64'd0);
        check("post_rst_x7", read_data2, 64'd0);

        // First edge after release accepts a write.
        wr(5'd2, 64'h0123_4567_89AB_CDEF);
        rd(5'd2, 5'd0);
        check("first_wr_x2", read_data1, 64'h0123_4567_89AB_CDEF);
        check("first_wr_x0", read_data2, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter WORD, default 64, SHALL set the data width of every register and data port.
REQ-002 Parameter NREGS, default 32, SHALL set the number of architectural registers; the address width SHALL be 5 bits.
REQ-003 clk  input  1  SHALL be the single clock; all writes occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 read_register1  input  5  SHALL be the read port 1 register index.
REQ-006 read_register2  input  5  SHALL be the read port 2 register index.
REQ-007 write_register  input  5  SHALL be the write port register index.
REQ-008 RegWrite  input  1  SHALL be the write enable, active high.
REQ-009 write_data  input  WORD  SHALL be the data to write.
REQ-010 read_data1  output  WORD  SHALL be the contents of register read_register1.
REQ-011 read_data2  output  WORD  SHALL be the contents of register read_register2.

Function
REQ-012 Storage SHALL be 32 registers X0..X31 of WORD bits each.
REQ-013 Reads SHALL be combinational: read_dataN follows read_registerN and register contents with zero clock latency.
REQ-014 A write SHALL occur on the rising clk edge only when RegWrite=1; register[write_register] takes write_data.
REQ-015 With RegWrite=0, no register SHALL change, regardless of write_register or write_data activity.
REQ-016 Register 31 (XZR) SHALL always read 0; writes to register 31 SHALL be silently discarded.
REQ-017 Register 0 SHALL be an ordinary writable register.
REQ-018 Both read ports MAY address the same register simultaneously, and SHALL then return identical data.
REQ-019 When a read port addresses the register being written in the same cycle (RegWrite=1), without REGFILE_BYPASS_EN the port SHALL return the old value until after the edge.
REQ-020 When a port addresses index 31 during a write to 31, the port SHALL return 0 in all configurations.

Reset
REQ-021 Asserting rst_n=0 SHALL immediately clear all registers to 0, independent of clk.
REQ-022 While rst_n=0, writes SHALL be ignored and both read outputs SHALL be 0.
REQ-023 Deassertion SHALL take effect without glitching outputs; the first write is accepted on the first rising edge with rst_n=1.

Configuration
REQ-024 The macro REGFILE_BYPASS_EN SHALL, when defined, enable write-through forwarding: if RegWrite=1, write_register==read_registerN and the index is not 31, read_dataN SHALL equal write_data combinationally in the same cycle.
REQ-025 With REGFILE_BYPASS_EN undefined, there SHALL be no forwarding path, as stated in REQ-019.

Structure
REQ-026 The shared package SHALL hold WORD (64), NREGS (32), the 5-bit register index type, and the constant ZERO_REG=31.
REQ-027 Read-port selection, including the zero-register and bypass logic, SHALL be a sub-module regfile_read_port, instantiated twice.
REQ-028 The storage array and write logic SHALL reside in regfile itself.

Verification
REQ-029 Reset test: pulse rst_n low mid-cycle, then read 1, 3, 29 and 31 -> all read 0 immediately, without waiting for a clock edge.
REQ-030 Basic write test: RegWrite=1, write_register=0, write_data=4783, clock; read_register1=0 -> 4783. Then read 1/3, 29/31 and 15/9 -> all 0.
REQ-031 Retarget test: write_register=13 with write_data=4783, clock; read_register1=13 -> 4783. Then RegWrite=0, write_data=3987, clock several edges -> register 13 still reads 4783.
REQ-032 Zero-register test: write 0xFFFF_FFFF_FFFF_FFFF to register 31, clock -> read_data1 and read_data2 at index 31 return 0.
REQ-033 Dual-port / same-cycle test: write 42 to register 7 while both ports read 7 -> returns 0 before the edge and 42 after (no bypass); with REGFILE_BYPASS_EN defined -> returns 42 in the same cycle.
REQ-034 Async reset mid-operation test: after registers 0 and 13 hold 4783, drop rst_n between edges -> both outputs go to 0 at once; a write attempted during reset is not retained after release.
